irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Interrupt controller: level/edge sources, mask, claim/EOI handshake, registered CPU request.
// Define IRQ_CTRL_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (lowest id wins).
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NUM_SRC-1:0] i_irq_src,
    input  logic [2:0]         i_addr,
    input  logic [7:0]         i_data,
    input  logic               i_rw,
    input  logic               i_en,
    output logic [7:0]         o_data,
    output logic               o_irq
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_CLAIM   = 3'd3;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, edge_q, sample_q, edge_pend_q;
    logic [NUM_SRC-1:0] pending, eligible, edge_set, edge_clr, claim_clr;
    logic               enable_q;
    logic [2:0]         claimed_id_q, winner;
    logic               win_valid, wr, rd, claim, eoi;
    logic               unused_claimed_id;

    assign wr    = i_en & ~i_rw;
    assign rd    = i_en & i_rw;
    assign claim = rd && (i_addr == ADDR_CLAIM) && (state_q == REQ) && win_valid;
    assign eoi   = wr && (i_addr == ADDR_CLAIM) && (state_q == SERVICE);

    // Edge sources report their sticky bit, level sources report the live input.
    assign pending  = (edge_q & edge_pend_q) | (~edge_q & i_irq_src);
    assign eligible = pending & mask_q & {NUM_SRC{enable_q}};

    // The claimed id is held for debug visibility only; nothing downstream consumes it.
    assign unused_claimed_id = ^claimed_id_q;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q;

    always_comb begin
        int idx;
        winner    = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_SRC;
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                winner    = 3'(idx);
            end
        end
    end

    // Pointer holds the id where the next search starts, i.e. last claimed id + 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr_q <= '0;
        end else if (claim) begin
            rr_ptr_q <= (winner == 3'(NUM_SRC - 1)) ? 3'd0 : winner + 3'd1;
        end
    end
`else
    always_comb begin
        winner    = '0;
        win_valid = |eligible;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        claim_clr = '0;
        edge_set  = (i_irq_src & ~sample_q) & edge_q;
        edge_clr  = '0;
        if (claim) begin
            claim_clr[winner] = 1'b1;
        end
        if (wr && i_addr == ADDR_SWTRIG) begin
            edge_set = edge_set | (i_data[NUM_SRC-1:0] & edge_q);
        end
        if (wr && i_addr == ADDR_PENDING) begin
            edge_clr = i_data[NUM_SRC-1:0];
        end
        edge_clr = edge_clr | claim_clr;
    end

    // Set is applied after clear so a simultaneous rising edge survives a W1C or claim.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sample_q     <= '0;
            edge_pend_q  <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            enable_q     <= 1'b0;
            claimed_id_q <= '0;
        end else begin
            sample_q    <= i_irq_src;
            edge_pend_q <= (edge_pend_q & ~edge_clr) | edge_set;
            if (wr && i_addr == ADDR_MASK) mask_q   <= i_data[NUM_SRC-1:0];
            if (wr && i_addr == ADDR_EDGE) edge_q   <= i_data[NUM_SRC-1:0];
            if (wr && i_addr == ADDR_CTRL) enable_q <= i_data[0];
            if (claim)                     claimed_id_q <= winner;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = REQ;
            REQ: begin
                if (claim)           state_d = SERVICE;
                else if (!win_valid) state_d = IDLE;
            end
            SERVICE: if (eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            o_irq   <= 1'b0;
        end else begin
            state_q <= state_d;
            o_irq   <= (state_d == REQ);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data <= 8'h00;
        end else if (rd) begin
            case (i_addr)
                ADDR_PENDING: o_data <= 8'(pending);
                ADDR_MASK:    o_data <= 8'(mask_q);
                ADDR_EDGE:    o_data <= 8'(edge_q);
                ADDR_CLAIM:   o_data <= claim ? {1'b1, 4'b0000, winner} : 8'h00;
                ADDR_CTRL:    o_data <= {7'b0000000, enable_q};
                default:      o_data <= 8'h00;
            endcase
        end
    end

endmodule
